id_ex_stage_reg: RTL and testbench

ID/EX pipeline register for the 16-bit, 8-register, 5-stage pipeline, with integrated load-use hazard detection, bubble insertion, flush, and a same-cycle writeback bypass. It captures decode-stage operands and control, then presents them as the `IE_*_out` signals consumed by the forwarding unit and the EX stage. It stalls IF/ID when a load in EX feeds the instruction in ID, because forwarding cannot cover that case. It freezes entirely on a memory (cache) stall.

---
 rtl/id_ex_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush, memory-stall freeze and a same-cycle writeback bypass.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   ID_*                  - decode-stage instruction, operands and control
//   WB_regWrite_out,
//   WB_writereg_out,
//   WB_data               - writeback port in the same cycle (bypass source)
//   mem_stall             - freeze every register, counter included
//   flush                 - redirect from EX; replace ID instruction by a bubble
//   IE_*_out              - registered fields presented to EX / forwarding
//   stall_IF_ID           - hold PC and IF/ID this cycle
//   load_use_count        - saturating count of load-use bubbles
module id_ex_stage_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ID_Instr,
  input  logic [15:0] ID_read1data,
  input  logic [15:0] ID_read2data,
  input  logic [15:0] ID_imm,
  input  logic [15:0] ID_PC_inc,
  input  logic        ID_uses_rs,
  input  logic        ID_uses_rt,
  input  logic        ID_regWrite,
  input  logic        ID_memRead,
  input  logic        ID_memWrite,
  input  logic [2:0]  ID_writereg,
  input  logic        ID_valid,
  input  logic        WB_regWrite_out,
  input  logic [2:0]  WB_writereg_out,
  input  logic [15:0] WB_data,
  input  logic        mem_stall,
  input  logic        flush,
  output logic [15:0] IE_Instr_out,
  output logic [15:0] IE_read1data_out,
  output logic [15:0] IE_read2data_out,
  output logic [15:0] IE_imm_out,
  output logic [15:0] IE_PC_inc_out,
  output logic        IE_regWrite_out,
  output logic        IE_memRead_out,
  output logic        IE_memWrite_out,
  output logic        IE_valid_out,
  output logic [2:0]  IE_writereg_out,
  output logic        stall_IF_ID,
  output logic [15:0] load_use_count
);

  logic [15:0] instr_q, instr_d;
  logic [15:0] rd1_q, rd1_d;
  logic [15:0] rd2_q, rd2_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] pc_q, pc_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        valid_q, valid_d;
  logic [2:0]  writereg_q, writereg_d;
  logic [15:0] load_use_count_q, load_use_count_d;

  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       hazard;

  assign id_rs = ID_Instr[10:8];
  assign id_rt = ID_Instr[7:5];

  // Only the registered EX state and ID inputs feed this; no WB path.
  assign hazard = valid_q & memread_q & ID_valid &
                  ((ID_uses_rs & (writereg_q == id_rs)) |
                   (ID_uses_rt & (writereg_q == id_rt)));

  assign stall_IF_ID = mem_stall | (hazard & ~flush);

  always_comb begin
    instr_d          = instr_q;
    rd1_d            = rd1_q;
    rd2_d            = rd2_q;
    imm_d            = imm_q;
    pc_d             = pc_q;
    regwrite_d       = regwrite_q;
    memread_d        = memread_q;
    memwrite_d       = memwrite_q;
    valid_d          = valid_q;
    writereg_d       = writereg_q;
    load_use_count_d = load_use_count_q;
    if (!mem_stall) begin
      if (flush || hazard) begin
        instr_d    = NOP_INSTR;
        rd1_d      = '0;
        rd2_d      = '0;
        imm_d      = '0;
        pc_d       = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        valid_d    = 1'b0;
        writereg_d = '0;
        // Flush has priority: a killed instruction does not count as a load-use bubble.
        if (!flush && load_use_count_q != '1) begin
          load_use_count_d = load_use_count_q + 16'd1;
        end
      end else begin
        instr_d    = ID_Instr;
        rd1_d      = (WB_regWrite_out && WB_writereg_out == id_rs) ? WB_data : ID_read1data;
        rd2_d      = (WB_regWrite_out && WB_writereg_out == id_rt) ? WB_data : ID_read2data;
        imm_d      = ID_imm;
        pc_d       = ID_PC_inc;
        regwrite_d = ID_regWrite & ID_valid;
        memread_d  = ID_memRead & ID_valid;
        memwrite_d = ID_memWrite & ID_valid;
        valid_d    = ID_valid;
        writereg_d = ID_writereg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q          <= NOP_INSTR;
      rd1_q            <= '0;
      rd2_q            <= '0;
      imm_q            <= '0;
      pc_q             <= '0;
      regwrite_q       <= 1'b0;
      memread_q        <= 1'b0;
      memwrite_q       <= 1'b0;
      valid_q          <= 1'b0;
      writereg_q       <= '0;
      load_use_count_q <= '0;
    end else begin
      instr_q          <= instr_d;
      rd1_q            <= rd1_d;
      rd2_q            <= rd2_d;
      imm_q            <= imm_d;
      pc_q             <= pc_d;
      regwrite_q       <= regwrite_d;
      memread_q        <= memread_d;
      memwrite_q       <= memwrite_d;
      valid_q          <= valid_d;
      writereg_q       <= writereg_d;
      load_use_count_q <= load_use_count_d;
    end
  end

  assign IE_Instr_out     = instr_q;
  assign IE_read1data_out = rd1_q;
  assign IE_read2data_out = rd2_q;
  assign IE_imm_out       = imm_q;
  assign IE_PC_inc_out    = pc_q;
  assign IE_regWrite_out  = regwrite_q;
  assign IE_memRead_out   = memread_q;
  assign IE_memWrite_out  = memwrite_q;
  assign IE_valid_out     = valid_q;
  assign IE_writereg_out  = writereg_q;
  assign load_use_count   = load_use_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, load-use bubble, flush priority,
// memory-stall freeze, WB bypass and counter saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ID_Instr, ID_read1data, ID_read2data, ID_imm, ID_PC_inc;
  logic        ID_uses_rs, ID_uses_rt, ID_regWrite, ID_memRead, ID_memWrite;
  logic [2:0]  ID_writereg;
  logic        ID_valid;
  logic        WB_regWrite_out;
  logic [2:0]  WB_writereg_out;
  logic [15:0] WB_data;
  logic        mem_stall, flush;
  logic [15:0] IE_Instr_out, IE_read1data_out, IE_read2data_out, IE_imm_out, IE_PC_inc_out;
  logic        IE_regWrite_out, IE_memRead_out, IE_memWrite_out, IE_valid_out;
  logic [2:0]  IE_writereg_out;
  logic        stall_IF_ID;
  logic [15:0] load_use_count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_Instr(ID_Instr), .ID_read1data(ID_read1data), .ID_read2data(ID_read2data),
    .ID_imm(ID_imm), .ID_PC_inc(ID_PC_inc),
    .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
    .ID_regWrite(ID_regWrite), .ID_memRead(ID_memRead), .ID_memWrite(ID_memWrite),
    .ID_writereg(ID_writereg), .ID_valid(ID_valid),
    .WB_regWrite_out(WB_regWrite_out), .WB_writereg_out(WB_writereg_out), .WB_data(WB_data),
    .mem_stall(mem_stall), .flush(flush),
    .IE_Instr_out(IE_Instr_out), .IE_read1data_out(IE_read1data_out),
    .IE_read2data_out(IE_read2data_out), .IE_imm_out(IE_imm_out), .IE_PC_inc_out(IE_PC_inc_out),
    .IE_regWrite_out(IE_regWrite_out), .IE_memRead_out(IE_memRead_out),
    .IE_memWrite_out(IE_memWrite_out), .IE_valid_out(IE_valid_out),
    .IE_writereg_out(IE_writereg_out), .stall_IF_ID(stall_IF_ID),
    .load_use_count(load_use_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [15:0] instr, input logic [15:0] r1, input logic [15:0] r2,
                        input logic urs, input logic urt, input logic rw, input logic mr,
                        input logic [2:0] wr, input logic v);
    ID_Instr     = instr;
    ID_read1data = r1;
    ID_read2data = r2;
    ID_imm       = r1 ^ 16'h00FF;
    ID_PC_inc    = r2 + 16'd2;
    ID_uses_rs   = urs;
    ID_uses_rt   = urt;
    ID_regWrite  = rw;
    ID_memRead   = mr;
    ID_memWrite  = 1'b0;
    ID_writereg  = wr;
    ID_valid     = v;
  endtask

  // LW r3 <- [r1]: rs=1, rt=1, rd=3
  task automatic id_load();
    set_id(16'h4123, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
  endtask

  // ADD r5 <- r3 + r4: rs=3, rt=4
  task automatic id_add();
    set_id(16'h0380, 16'hAAAA, 16'hBBBB, 1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
    WB_regWrite_out = 1'b0; WB_writereg_out = 3'd0; WB_data = 16'h0;
    set_id(16'hFFFF, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1);
    ID_memWrite = 1'b1;
    #2;

    // Reset with nonzero ID inputs
    tick();
    chk("rst_instr", IE_Instr_out, 16'h0800);
    chk("rst_rd1", IE_read1data_out, 16'h0);
    chk("rst_rd2", IE_read2data_out, 16'h0);
    chk("rst_imm", IE_imm_out, 16'h0);
    chk("rst_pc", IE_PC_inc_out, 16'h0);
    chk("rst_ctl", {12'h0, IE_regWrite_out, IE_memRead_out, IE_memWrite_out, IE_valid_out}, 16'h0);
    chk("rst_wr", {13'h0, IE_writereg_out}, 16'h0);
    chk("rst_stall", {15'h0, stall_IF_ID}, 16'h0);
    chk("rst_cnt", load_use_count, 16'h0);

    // First edge after reset: normal load of the LW
    rst_n = 1'b1;
    id_load();
    tick();
    chk("ld_instr", IE_Instr_out, 16'h4123);
    chk("ld_rd1", IE_read1data_out, 16'h1111);
    chk("ld_imm", IE_imm_out, 16'h11EE);
    chk("ld_pc", IE_PC_inc_out, 16'h2224);
    chk("ld_ctl", {12'h0, IE_regWrite_out, IE_memRead_out, IE_memWrite_out, IE_valid_out}, 16'h000D);
    chk("ld_wr", {13'h0, IE_writereg_out}, 16'h3);

    // Load-use: ADD reads r3 while LW r3 is in EX
    id_add();
    #1;
    chk("lu_stall", {15'h0, stall_IF_ID}, 16'h1);
    tick();
    chk("lu_bub_instr", IE_Instr_out, 16'h0800);
    chk("lu_bub_valid", {15'h0, IE_valid_out}, 16'h0);
    chk("lu_bub_rd1", IE_read1data_out, 16'h0);
    chk("lu_bub_wr", {13'h0, IE_writereg_out}, 16'h0);
    chk("lu_cnt", load_use_count, 16'h1);
    chk("lu_stall_clr", {15'h0, stall_IF_ID}, 16'h0);
    tick();
    chk("lu_add_instr", IE_Instr_out, 16'h0380);
    chk("lu_add_rd1", IE_read1data_out, 16'hAAAA);
    chk("lu_add_rd2", IE_read2data_out, 16'hBBBB);
    chk("lu_add_wr", {13'h0, IE_writereg_out}, 16'h5);
    chk("lu_add_cnt", load_use_count, 16'h1);

    // Flush together with load-use: bubble, no stall, no count
    id_load();
    tick();
    id_add();
    flush = 1'b1;
    #1;
    chk("fl_stall", {15'h0, stall_IF_ID}, 16'h0);
    tick();
    chk("fl_instr", IE_Instr_out, 16'h0800);
    chk("fl_valid", {15'h0, IE_valid_out}, 16'h0);
    chk("fl_cnt", load_use_count, 16'h1);
    flush = 1'b0;

    // Memory stall with flush and changing ID inputs: everything frozen
    id_load();
    tick();
    mem_stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(16'h0700 + 16'(i), 16'h9000 + 16'(i), 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
      #1;
      chk("ms_stall", {15'h0, stall_IF_ID}, 16'h1);
      tick();
      chk("ms_instr", IE_Instr_out, 16'h4123);
      chk("ms_rd1", IE_read1data_out, 16'h1111);
      chk("ms_ctl", {12'h0, IE_regWrite_out, IE_memRead_out, IE_memWrite_out, IE_valid_out}, 16'h000D);
      chk("ms_cnt", load_use_count, 16'h1);
    end
    mem_stall = 1'b0;
    flush = 1'b0;

    // WB bypass on rt only
    WB_regWrite_out = 1'b1; WB_writereg_out = 3'd5; WB_data = 16'hBEEF;
    set_id(16'h02A0, 16'h5678, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1);
    #1;
    chk("wb_stall", {15'h0, stall_IF_ID}, 16'h0);
    tick();
    chk("wb_rd2", IE_read2data_out, 16'hBEEF);
    chk("wb_rd1", IE_read1data_out, 16'h5678);
    // WB bypass on rs only
    WB_writereg_out = 3'd2; WB_data = 16'hCAFE;
    tick();
    chk("wb_rs_rd1", IE_read1data_out, 16'hCAFE);
    chk("wb_rs_rd2", IE_read2data_out, 16'h1234);
    WB_regWrite_out = 1'b0;

    // Invalid ID instruction: control gated off
    set_id(16'h1234, 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0);
    tick();
    chk("inv_instr", IE_Instr_out, 16'h1234);
    chk("inv_ctl", {12'h0, IE_regWrite_out, IE_memRead_out, IE_memWrite_out, IE_valid_out}, 16'h0);

    // Counter saturation from a preloaded 16'hFFFE
    force dut.load_use_count_q = 16'hFFFE;
    #1;
    release dut.load_use_count_q;
    #1;
    chk("sat_pre", load_use_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      id_load();
      tick();
      id_add();
      tick();
      chk("sat_bub", IE_Instr_out, 16'h0800);
      chk("sat_cnt", load_use_count, 16'hFFFF);
    end

    // Reset mid-operation overrides stall and flush
    id_load();
    tick();
    mem_stall = 1'b1;
    flush = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("mrst_instr", IE_Instr_out, 16'h0800);
    chk("mrst_valid", {15'h0, IE_valid_out}, 16'h0);
    chk("mrst_rd1", IE_read1data_out, 16'h0);
    chk("mrst_cnt", load_use_count, 16'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
